// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: buffered 1-to-2 stream demultiplexer with a show-ahead FIFO per output.
// Defining DEMUX_STATS_EN adds the saturating stall_cnt output.
module demux_1to2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   ready,
  output logic [WIDTH-1:0]       head,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic pop;
  assign valid = count != '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign pop   = valid && ready;
  // Memory is not reset, so the head is masked to zero while empty.
  assign head  = valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count  <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

module demux_1to2_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_select,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out2_data,
  output logic                   out2_valid,
  input  logic                   out2_ready,
  output logic [$clog2(DEPTH):0] count1,
  output logic [$clog2(DEPTH):0] count2
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);
  logic full1, full2, accept;
  // Ready depends only on select and registered occupancy; a full FIFO never passes through.
  assign in_ready = in_select ? !full2 : !full1;
  assign accept   = in_valid && in_ready;
  demux_1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .push(accept && !in_select), .wr_data(in_data),
    .ready(out1_ready), .head(out1_data), .valid(out1_valid), .full(full1), .count(count1)
  );
  demux_1to2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
    .clk(clk), .rst_n(rst_n), .push(accept && in_select), .wr_data(in_data),
    .ready(out2_ready), .head(out2_data), .valid(out2_valid), .full(full2), .count(count2)
  );
`ifdef DEMUX_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_cnt <= '0;
    else if (in_valid && !in_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_demux_1to2_stream.sv
// tb_demux_1to2_stream: vector table, directed corner sequences and a queue-model random run.
module tb_demux_1to2_stream;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] in_data = 0, out1_data, out2_data;
  logic in_select = 0, in_valid = 0, in_ready;
  logic out1_valid, out2_valid, out1_ready = 0, out2_ready = 0;
  logic [2:0] count1, count2;
  int checks = 0, failures = 0;
`ifdef DEMUX_STATS_EN
  logic [15:0] stall_cnt;
`endif

  demux_1to2_stream #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_select(in_select),
    .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .count1(count1), .count2(count2)
`ifdef DEMUX_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int v, s, d, r1, r2, ir, v1, d1, c1, v2, d2, c2;
  } vec_t;
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int v, input int s, input int d, input int r1, input int r2);
    in_valid = 1'(v); in_select = 1'(s); in_data = 32'(d);
    out1_ready = 1'(r1); out2_ready = 1'(r2);
  endtask

  task automatic chk_state(input string tag, input int v1, input int d1, input int c1,
                           input int v2, input int d2, input int c2);
    chk({tag, " out1_valid"}, 32'(out1_valid), 32'(v1));
    chk({tag, " out1_data"}, out1_data, 32'(d1));
    chk({tag, " count1"}, 32'(count1), 32'(c1));
    chk({tag, " out2_valid"}, 32'(out2_valid), 32'(v2));
    chk({tag, " out2_data"}, out2_data, 32'(d2));
    chk({tag, " count2"}, 32'(count2), 32'(c2));
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int q1[$], q2[$];
  int hold, stall_model;

  initial begin
    vecs[0]  = '{1, 0, 452, 1, 1, 1, 1, 452, 1, 0, 0, 0};
    vecs[1]  = '{1, 1, 167, 1, 1, 1, 0, 0, 0, 1, 167, 1};
    vecs[2]  = '{1, 1, 252, 1, 1, 1, 0, 0, 0, 1, 252, 1};
    vecs[3]  = '{1, 0, 65, 1, 1, 1, 1, 65, 1, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0};
    vecs[6]  = '{1, 0, 2, 0, 1, 1, 1, 1, 2, 0, 0, 0};
    vecs[7]  = '{1, 0, 3, 0, 1, 1, 1, 1, 3, 0, 0, 0};
    vecs[8]  = '{1, 0, 4, 0, 1, 1, 1, 1, 4, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 4, 0, 0, 0};
    vecs[10] = '{1, 1, 165, 0, 0, 1, 1, 1, 4, 1, 165, 1};
    vecs[11] = '{1, 0, 77, 1, 0, 0, 1, 2, 3, 1, 165, 1};
    vecs[12] = '{1, 0, 77, 1, 1, 1, 1, 3, 3, 0, 0, 0};
    vecs[13] = '{0, 0, 0, 1, 1, 1, 1, 4, 2, 0, 0, 0};
    vecs[14] = '{0, 0, 0, 1, 1, 1, 1, 77, 1, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};

    do_reset();
    #1;
    chk("reset in_ready", 32'(in_ready), 1);
    chk_state("reset", 0, 0, 0, 0, 0, 0);
`ifdef DEMUX_STATS_EN
    chk("reset stall_cnt", 32'(stall_cnt), 0);
`endif

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r1, vecs[i].r2);
      #1;
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].ir));
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].v1, vecs[i].d1, vecs[i].c1,
                vecs[i].v2, vecs[i].d2, vecs[i].c2);
    end

    // Alternating pushes with both consumers ready wrap both pointer sets.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, i % 2, 100 + i, 1, 1);
      tick();
      if (i % 2 == 0) chk_state($sformatf("wrap%0d", i), 1, 100 + i, 1, 0, 0, 0);
      else chk_state($sformatf("wrap%0d", i), 0, 0, 0, 1, 100 + i, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 1, 1);
    tick();
    chk_state("wrap drain", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, i >= 3, 10 + i, 0, 0);
      tick();
    end
    chk("pre-reset count1", 32'(count1), 3);
    chk("pre-reset count2", 32'(count2), 2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk_state("async reset", 0, 0, 0, 0, 0, 0);
    chk("async reset in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1;
    drive(1, 1, 2, 0, 0);
    tick();
    chk_state("post-reset", 0, 0, 0, 1, 2, 1);

`ifdef DEMUX_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, i, 0, 0);
      tick();
    end
    chk("stall before", 32'(stall_cnt), 0);
    @(negedge clk);
    drive(1, 0, 9, 0, 0);
    repeat (7) tick();
    chk("stall_cnt 7", 32'(stall_cnt), 7);
`endif

    // Random traffic against a queue model.
    do_reset();
    q1.delete(); q2.delete();
    stall_model = 0;
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_select = 1'($urandom_range(0, 1));
        in_data = $urandom;
      end
      out1_ready = 1'($urandom_range(0, 2) == 0 ? 0 : (c / 100) % 2);
      out2_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      begin
        automatic bit exp_ir = (in_select ? q2.size() : q1.size()) < DEPTH;
        automatic bit p1 = q1.size() > 0 && out1_ready;
        automatic bit p2 = q2.size() > 0 && out2_ready;
        automatic bit acc = in_valid && exp_ir;
        chk("rand in_ready", 32'(in_ready), 32'(exp_ir));
        if (in_valid && !exp_ir && stall_model < 16'hFFFF) stall_model++;
        hold = in_valid && !exp_ir;
        tick();
        if (p1) void'(q1.pop_front());
        if (p2) void'(q2.pop_front());
        if (acc) begin
          if (in_select) q2.push_back(in_data);
          else q1.push_back(in_data);
        end
      end
      chk_state("rand", q1.size() > 0, q1.size() > 0 ? q1[0] : 0, q1.size(),
                q2.size() > 0, q2.size() > 0 ? q2[0] : 0, q2.size());
`ifdef DEMUX_STATS_EN
      chk("rand stall_cnt", 32'(stall_cnt), 32'(stall_model));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
